// File: rtl/shared_counters_pkg.sv
// Shared definitions for the shared_counters read path: command encodings
// and the read-collector state type.
package shared_counters_pkg;

    localparam logic [2:0] CMD_IDLE    = 3'b000;
    localparam logic [2:0] CMD_INC     = 3'b001;
    localparam logic [2:0] CMD_NEW     = 3'b010;
    localparam logic [2:0] CMD_DEALLOC = 3'b011;
    localparam logic [2:0] CMD_LOAD    = 3'b100;
    localparam logic [2:0] CMD_READ    = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_RESP = 2'd2
    } collector_state_t;

endpackage

// File: rtl/counter_read_packer.sv
// Packs a G-bit chunk stream LSB-first into a DATA_W-bit word, counting
// chunks (saturating at 255) and flagging chunks beyond the word's capacity.
module counter_read_packer #(
    parameter int G      = 4,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              chunk_valid,
    input  logic [G-1:0]      chunk,
    output logic [DATA_W-1:0] data,
    output logic [7:0]        nchunks,
    output logic              ovf
);

    localparam int MAX_CHUNKS = DATA_W / G;

    logic [DATA_W-1:0] data_r;
    logic [7:0]        nchunks_r;
    logic              ovf_r;

    // Chunk count doubles as the write index; chunks past capacity only set ovf.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            data_r    <= {DATA_W{1'b0}};
            nchunks_r <= 8'd0;
            ovf_r     <= 1'b0;
        end else if (chunk_valid) begin
            if (int'(nchunks_r) < MAX_CHUNKS) begin
                data_r[int'(nchunks_r) * G +: G] <= chunk;
            end else begin
                ovf_r <= 1'b1;
            end
            if (nchunks_r != 8'd255) begin
                nchunks_r <= nchunks_r + 8'd1;
            end
        end
    end

    assign data    = data_r;
    assign nchunks = nchunks_r;
    assign ovf     = ovf_r;

endmodule

// File: rtl/counter_read_collector.sv
// Read-path collector for shared_counters: issues READ for a requested id,
// gathers the chunk stream into a word and returns it on a response port.
// Optional read watchdog enabled by defining COUNTER_READ_TIMEOUT_EN.
module counter_read_collector
    import shared_counters_pkg::*;
#(
    parameter int N           = 10,
    parameter int G           = 4,
    parameter int DATA_W      = 64,
    parameter int TIMEOUT_CYC = 64,
    localparam int IW         = (N > 1) ? $clog2(N) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [IW-1:0]     req_id,
    output logic [2:0]        cmd_out,
    output logic [IW-1:0]     cmd_id,
    input  logic [G-1:0]      rdata_in,
    input  logic              rdata_valid,
    input  logic              rdata_last,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic [IW-1:0]     resp_id,
    output logic [7:0]        resp_nchunks,
    output logic              resp_ovf,
    output logic              resp_timeout
);

    collector_state_t state_r;
    logic             req_ready_r;
    logic [2:0]       cmd_out_r;
    logic [IW-1:0]    cmd_id_r;
    logic             resp_valid_r;
    logic [IW-1:0]    resp_id_r;
    logic             timeout_r;
    logic             req_fire_s;
    logic             chunk_fire_s;
    logic             wd_expired_s;

    assign req_fire_s   = (state_r == ST_IDLE) && req_valid && req_ready_r;
    assign chunk_fire_s = (state_r == ST_READ) && rdata_valid;

`ifdef COUNTER_READ_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    logic [WD_W-1:0] wd_r;

    // Counts consecutive chunk-less READ cycles.
    always_ff @(posedge clk) begin
        if (rst || (state_r != ST_READ) || rdata_valid) begin
            wd_r <= {WD_W{1'b0}};
        end else begin
            wd_r <= wd_r + {{(WD_W-1){1'b0}}, 1'b1};
        end
    end

    assign wd_expired_s = (state_r == ST_READ) && !rdata_valid &&
                          (wd_r == WD_W'(TIMEOUT_CYC - 1));
`else
    assign wd_expired_s = 1'b0;
`endif

    // Collector FSM with registered handshake and command outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            req_ready_r  <= 1'b1;
            cmd_out_r    <= CMD_IDLE;
            cmd_id_r     <= {IW{1'b0}};
            resp_valid_r <= 1'b0;
            resp_id_r    <= {IW{1'b0}};
            timeout_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_fire_s) begin
                        state_r     <= ST_READ;
                        req_ready_r <= 1'b0;
                        cmd_out_r   <= CMD_READ;
                        cmd_id_r    <= req_id;
                        resp_id_r   <= req_id;
                        timeout_r   <= 1'b0;
                    end
                end
                ST_READ: begin
                    if (rdata_valid && rdata_last) begin
                        state_r      <= ST_RESP;
                        cmd_out_r    <= CMD_IDLE;
                        resp_valid_r <= 1'b1;
                    end else if (wd_expired_s) begin
                        state_r      <= ST_RESP;
                        cmd_out_r    <= CMD_IDLE;
                        resp_valid_r <= 1'b1;
                        timeout_r    <= 1'b1;
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        state_r      <= ST_IDLE;
                        resp_valid_r <= 1'b0;
                        req_ready_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r      <= ST_IDLE;
                    req_ready_r  <= 1'b1;
                    cmd_out_r    <= CMD_IDLE;
                    resp_valid_r <= 1'b0;
                end
            endcase
        end
    end

    counter_read_packer #(
        .G      (G),
        .DATA_W (DATA_W)
    ) u_packer (
        .clk         (clk),
        .rst         (rst),
        .clr         (req_fire_s),
        .chunk_valid (chunk_fire_s),
        .chunk       (rdata_in),
        .data        (resp_data),
        .nchunks     (resp_nchunks),
        .ovf         (resp_ovf)
    );

    assign req_ready    = req_ready_r;
    assign cmd_out      = cmd_out_r;
    assign cmd_id       = cmd_id_r;
    assign resp_valid   = resp_valid_r;
    assign resp_id      = resp_id_r;
    assign resp_timeout = timeout_r;

endmodule

// File: tb/tb_counter_read_collector.sv
// Scoreboard bench for counter_read_collector: expected responses are queued
// as requests are issued and compared when the response appears.
module tb_counter_read_collector;

    localparam int N      = 10;
    localparam int G      = 4;
    localparam int DATA_W = 64;
    localparam int IW     = 4;
    localparam int TO     = 64;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic [IW-1:0]     req_id;
    logic [2:0]        cmd_out;
    logic [IW-1:0]     cmd_id;
    logic [G-1:0]      rdata_in;
    logic              rdata_valid;
    logic              rdata_last;
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_data;
    logic [IW-1:0]     resp_id;
    logic [7:0]        resp_nchunks;
    logic              resp_ovf;
    logic              resp_timeout;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [IW-1:0]     id;
        logic [7:0]        n;
        logic              ovf;
        logic              to;
    } resp_t;

    resp_t exp_q[$];
    resp_t e;
    int    n_tests = 0;
    int    n_fail  = 0;
    bit    ok;

    counter_read_collector #(.N(N), .G(G), .DATA_W(DATA_W), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_id(req_id),
        .cmd_out(cmd_out), .cmd_id(cmd_id), .rdata_in(rdata_in), .rdata_valid(rdata_valid),
        .rdata_last(rdata_last), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_id(resp_id), .resp_nchunks(resp_nchunks),
        .resp_ovf(resp_ovf), .resp_timeout(resp_timeout)
    );

    always #5 clk = ~clk;

    function automatic resp_t observed();
        return {resp_data, resp_id, resp_nchunks, resp_ovf, resp_timeout};
    endfunction

    // All drive tasks start and end at a negedge.
    task automatic send_req(input logic [IW-1:0] id);
        req_valid = 1'b1; req_id = id;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic send_chunk(input logic [G-1:0] v, input logic last);
        rdata_valid = 1'b1; rdata_in = v; rdata_last = last;
        @(negedge clk);
        rdata_valid = 1'b0; rdata_last = 1'b0;
    endtask

    task automatic wait_resp(output bit got);
        for (int i = 0; i < 200; i++) begin
            if (resp_valid === 1'b1) break;
            @(negedge clk);
        end
        got = (resp_valid === 1'b1);
    endtask

    task automatic accept_resp();
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        n_tests++; if (cmd_out !== 3'b000) begin n_fail++; $display("FAIL reset_cmd got %b exp 000", cmd_out); end
        n_tests++; if (cmd_id !== 4'd0) begin n_fail++; $display("FAIL reset_cmd_id got %0d exp 0", cmd_id); end
        n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready got %b exp 1", req_ready); end
        n_tests++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid got %b exp 0", resp_valid); end
        n_tests++; if (observed() !== resp_t'(0)) begin n_fail++; $display("FAIL reset_resp_fields got %h exp 0", observed()); end
    endtask

    task automatic test_full_read();
        exp_q.push_back('{data: {16{4'hA}}, id: 4'd0, n: 8'd16, ovf: 1'b0, to: 1'b0});
        n_tests++; if (cmd_out !== 3'b000) begin n_fail++; $display("FAIL full_cmd_pre got %b exp 000", cmd_out); end
        send_req(4'd0);
        for (int k = 0; k < 16; k++) begin
            n_tests++; if (cmd_out !== 3'b101) begin n_fail++; $display("FAIL full_cmd_read k=%0d got %b exp 101", k, cmd_out); end
            send_chunk(4'hA, k == 15);
        end
        n_tests++; if (cmd_out !== 3'b000 || resp_valid !== 1'b1) begin n_fail++; $display("FAIL full_after_last cmd %b valid %b exp 000/1", cmd_out, resp_valid); end
        wait_resp(ok);
        e = exp_q.pop_front();
        n_tests++; if (!ok || observed() !== e) begin n_fail++; $display("FAIL full_resp got %h exp %h", observed(), e); end
        accept_resp();
        n_tests++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin n_fail++; $display("FAIL full_return_idle ready %b valid %b exp 1/0", req_ready, resp_valid); end
    endtask

    task automatic test_short_read();
        exp_q.push_back('{data: 64'h321, id: 4'd3, n: 8'd3, ovf: 1'b0, to: 1'b0});
        send_req(4'd3);
        n_tests++; if (cmd_id !== 4'd3 || req_ready !== 1'b0) begin n_fail++; $display("FAIL short_cmd_id got %0d ready %b exp 3/0", cmd_id, req_ready); end
        send_chunk(4'h1, 1'b0);
        send_chunk(4'h2, 1'b0);
        send_chunk(4'h3, 1'b1);
        wait_resp(ok);
        e = exp_q.pop_front();
        n_tests++; if (!ok || observed() !== e) begin n_fail++; $display("FAIL short_resp got %h exp %h", observed(), e); end
        accept_resp();
    endtask

    task automatic test_overflow();
        exp_q.push_back('{data: 64'hFEDC_BA98_7654_3210, id: 4'd9, n: 8'd18, ovf: 1'b1, to: 1'b0});
        send_req(4'd9);
        for (int k = 0; k < 18; k++) send_chunk(4'(k % 16), k == 17);
        wait_resp(ok);
        e = exp_q.pop_front();
        n_tests++; if (!ok || observed() !== e) begin n_fail++; $display("FAIL ovf_resp got %h exp %h", observed(), e); end
        accept_resp();
    endtask

    task automatic test_backpressure();
        int bad;
        exp_q.push_back('{data: 64'h87, id: 4'd5, n: 8'd2, ovf: 1'b0, to: 1'b0});
        send_req(4'd5);
        send_chunk(4'h7, 1'b0);
        send_chunk(4'h8, 1'b1);
        req_valid = 1'b1; req_id = 4'd2;
        bad = 0;
        for (int c = 0; c < 5; c++) begin
            rdata_valid = 1'($urandom_range(0, 1));
            rdata_in    = 4'($urandom_range(0, 15));
            rdata_last  = 1'($urandom_range(0, 1));
            @(negedge clk);
            n_tests++;
            if (observed() !== exp_q[0] || req_ready !== 1'b0 || resp_valid !== 1'b1 || cmd_out !== 3'b000) begin
                n_fail++;
                $display("FAIL bp_hold c=%0d got %h ready %b valid %b cmd %b exp %h/0/1/000", c, observed(), req_ready, resp_valid, cmd_out, exp_q[0]);
            end
        end
        rdata_valid = 1'b0; rdata_last = 1'b0;
        e = exp_q.pop_front();
        n_tests++; if (observed() !== e) begin n_fail++; $display("FAIL bp_resp got %h exp %h", observed(), e); end
        exp_q.push_back('{data: 64'h5, id: 4'd2, n: 8'd1, ovf: 1'b0, to: 1'b0});
        accept_resp();
        n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_after got %b exp 1", req_ready); end
        @(negedge clk);
        req_valid = 1'b0;
        n_tests++; if (cmd_out !== 3'b101 || cmd_id !== 4'd2) begin n_fail++; $display("FAIL bp_next_req cmd %b id %0d exp 101/2", cmd_out, cmd_id); end
        send_chunk(4'h5, 1'b1);
        wait_resp(ok);
        e = exp_q.pop_front();
        n_tests++; if (!ok || observed() !== e) begin n_fail++; $display("FAIL bp_single_resp got %h exp %h", observed(), e); end
        accept_resp();
    endtask

    task automatic test_reset_mid_read();
        int seen;
        send_req(4'd7);
        send_chunk(4'h1, 1'b0);
        send_chunk(4'h2, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_tests++;
        if (cmd_out !== 3'b000 || req_ready !== 1'b1 || resp_valid !== 1'b0 || observed() !== resp_t'(0)) begin
            n_fail++;
            $display("FAIL rst_mid cmd %b ready %b valid %b fields %h exp 000/1/0/0", cmd_out, req_ready, resp_valid, observed());
        end
        seen = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (resp_valid !== 1'b0) seen++;
        end
        n_tests++; if (seen != 0) begin n_fail++; $display("FAIL rst_no_resp got %0d valid cycles exp 0", seen); end
        exp_q.push_back('{data: 64'hF, id: 4'd4, n: 8'd1, ovf: 1'b0, to: 1'b0});
        send_req(4'd4);
        send_chunk(4'hF, 1'b1);
        wait_resp(ok);
        e = exp_q.pop_front();
        n_tests++; if (!ok || observed() !== e) begin n_fail++; $display("FAIL rst_then_read got %h exp %h", observed(), e); end
        accept_resp();
    endtask

`ifdef COUNTER_READ_TIMEOUT_EN
    task automatic test_timeout();
        int cyc;
        exp_q.push_back('{data: 64'h0, id: 4'd1, n: 8'd0, ovf: 1'b0, to: 1'b1});
        send_req(4'd1);
        cyc = 0;
        while (resp_valid !== 1'b1 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        n_tests++; if (cyc < TO - 2 || cyc > TO) begin n_fail++; $display("FAIL to_latency got %0d cycles exp %0d..%0d", cyc, TO - 2, TO); end
        e = exp_q.pop_front();
        n_tests++; if (resp_valid !== 1'b1 || observed() !== e) begin n_fail++; $display("FAIL to_resp got %h exp %h", observed(), e); end
        accept_resp();
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL global_time_limit reached exp completion");
        $fatal(1, "time limit");
    end

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_id = 4'd0; rdata_in = 4'd0;
        rdata_valid = 1'b0; rdata_last = 1'b0; resp_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_full_read();
        test_short_read();
        test_overflow();
        test_backpressure();
`ifdef COUNTER_READ_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid_read();
        n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain got %0d left exp 0", exp_q.size()); end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/counter_read_collector.md
# counter_read_collector

Downstream companion to `shared_counters` for its read path. It accepts a read request (counter id) on a valid/ready port and drives `command_in=READ` plus `id` into `shared_counters`. It then collects the G-bit `rdata_out` chunk stream until `last`, packs the chunks LSB-first into a 64-bit word, and returns the word with its id on a valid/ready response port.

## Interface
Parameters:
- `N`, 10: number of counters; id width `IW = $clog2(N)`.
- `G`, 4: chunk width of the `shared_counters` read stream.
- `DATA_W`, 64: packed result width; `MAX_CHUNKS = DATA_W/G`, and `G` must divide `DATA_W`.
- `TIMEOUT_CYC`, 64: watchdog limit in cycles (used only with the macro).

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: reset, synchronous, active-high.
- `req_valid`, in, 1: read request valid.
- `req_ready`, out, 1: request accepted when `req_valid && req_ready`.
- `req_id`, in, IW: counter to read.
- `cmd_out`, out, 3: connects to `shared_counters.command_in`; only `3'b000` (idle) or `3'b101` (read) is driven.
- `cmd_id`, out, IW: connects to `shared_counters.id`.
- `rdata_in`, in, G: from `rdata_out`.
- `rdata_valid`, in, 1: from `valid_data_out`.
- `rdata_last`, in, 1: from `last`.
- `resp_valid`, out, 1: response valid.
- `resp_ready`, in, 1: response consumed when `resp_valid && resp_ready`.
- `resp_data`, out, DATA_W: packed counter value.
- `resp_id`, out, IW: id of the counter that was read.
- `resp_nchunks`, out, 8: number of chunks received, saturating at 255.
- `resp_ovf`, out, 1: more than `MAX_CHUNKS` chunks were received.
- `resp_timeout`, out, 1: the watchdog ended the read.

## Operation
- FSM states are IDLE, READ and RESP.
- IDLE:
  - `req_ready=1`.
  - On a request handshake: latch `req_id`, clear the packing register, the chunk count and the flags, then go to READ.
- READ:
  - `cmd_out=3'b101` and `cmd_id` = latched id.
  - On each cycle with `rdata_valid`, chunk index k (0-based) is written to `resp_data[k*G +: G]`.
  - Chunks with k ≥ MAX_CHUNKS are dropped and set `resp_ovf`.
  - `resp_nchunks` increments on every accepted chunk.
  - `rdata_valid && rdata_last` accepts that chunk and moves the FSM to RESP.
- RESP:
  - `cmd_out=3'b000`, `resp_valid=1`.
  - All response outputs are held stable until `resp_ready`; the FSM then returns to IDLE.
- `rdata_valid` outside READ is ignored and changes no state.
- `req_ready=0` in READ and RESP.
- Bits above the last received chunk read as 0.

## Timing
- All outputs are registered.
- Reset values: `cmd_out=000`, `cmd_id=0`, `req_ready=1`, `resp_valid=0`, and `resp_data`, `resp_id`, `resp_nchunks`, `resp_ovf`, `resp_timeout` all 0. FSM goes to IDLE.
- Request accepted at edge t:
  - `cmd_out=101` from t+1.
  - The first chunk may be accepted at t+1.
- Last chunk accepted at edge u:
  - `cmd_out=000` and `resp_valid=1` from u+1.
- Response accepted at edge v: IDLE and `req_ready=1` from v+1. The minimum gap between request acceptances is therefore 1 idle cycle.
- Reset asserted mid-READ or mid-RESP: the pending read is abandoned, no response is produced, and the FSM is in IDLE with `cmd_out=000` after the reset edge.
- With `rdata_valid && rdata_last` on the first READ cycle, a single-chunk response is produced (`resp_nchunks=1`).

## Configuration
- `COUNTER_READ_TIMEOUT_EN` defined:
  - A cycle counter runs in READ and is cleared on each `rdata_valid`.
  - When it reaches `TIMEOUT_CYC` with no chunk in that cycle, the FSM goes to RESP with `resp_timeout=1` and the data packed so far.
- Undefined:
  - No counter is built; READ waits indefinitely for `last`.
  - The `resp_timeout` port remains and is tied 0.

## Structure
- `shared_counters_pkg` holds:
  - the command encodings `CMD_IDLE=3'b000`, `CMD_INC=3'b001`, `CMD_NEW=3'b010`, `CMD_DEALLOC=3'b011`, `CMD_LOAD=3'b100`, `CMD_READ=3'b101`;
  - the `collector_state_t` enum.
- One sub-module, `counter_read_packer`, holds:
  - the packing register, chunk index and overflow logic;
  - inputs `clr`, `chunk_valid`, `chunk`;
  - outputs `data`, `nchunks`, `ovf`.
- The FSM, handshakes and watchdog stay in the top module.

## Test plan
- Reset: hold `rst` for 2 cycles, then release. Expect `cmd_out=000`, `req_ready=1`, `resp_valid=0` and all response fields 0.
- Full read: request id=0, then 16 chunks of `4'hA` with `last` on the 16th. Expect:
  - `resp_data=64'hAAAA_AAAA_AAAA_AAAA`, `resp_id=0`, `resp_nchunks=16`, `resp_ovf=0`;
  - `cmd_out=101` exactly from the cycle after acceptance through the `last` cycle.
- Short read: id=3, chunks 1, 2, 3 with `last` on the third. Expect `resp_data=64'h321`, `resp_nchunks=3`.
- Overflow: 18 chunks with value = index mod 16, `last` on the 18th. Expect:
  - `resp_ovf=1`, `resp_nchunks=18`;
  - `resp_data=64'hFEDC_BA98_7654_3210`.
- Backpressure: hold `resp_ready=0` for 5 cycles with `req_valid=1` and stray `rdata_valid` pulses. Expect:
  - response fields stable and `req_ready=0`;
  - no new request accepted until the response is taken.
- Timeout (macro defined) and reset mid-READ:
  - Request with no chunks for 64 cycles: `resp_timeout=1`, `resp_nchunks=0`, `resp_data=0`.
  - Separately, assert `rst` after 2 chunks: no response, and IDLE follows.
